sprite_ram_loader: RTL and testbench

Writer side of the sprite memory path: accepts a row-major stream of 16-bit pixel words over a valid/ready handshake and stores them into an internal sprite RAM. The renderer reads that RAM with the same pixel-coordinate addressing the sprite ROMs use. It sits between the asset-load path (UART/SD bridge) and the VGA pixel mux, so sprites can be replaced at runtime instead of being fixed at synthesis.

---
 rtl/sprite_ram_loader.sv | 130 +++++++++++++
 tb/tb_sprite_ram_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_ram_loader.sv
// Sprite RAM writer: stores a row-major valid/ready pixel stream, serves registered raster reads.
// Optional: define SPRITE_RAM_LOADER_READ_GUARD_EN to blank rd_data while a load is in progress.
module sprite_ram_loader #(
  parameter int SPRITE_WIDTH  = 32,
  parameter int SPRITE_HEIGHT = 32,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic [9:0]            current_pixel_x,
  input  logic [9:0]            current_pixel_y,
  input  logic [9:0]            posx,
  input  logic [9:0]            posy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_hit
);
  // state | meaning
  // IDLE  | waiting for start, wr_ready low, stray words ignored
  // LOAD  | accepting one pixel word per handshake into the RAM
  // DONE  | one-cycle done pulse, then back to IDLE

  localparam int N  = SPRITE_WIDTH * SPRITE_HEIGHT;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (SPRITE_WIDTH > 1) ? $clog2(SPRITE_WIDTH) : 1;
  localparam int RW = $clog2(SPRITE_HEIGHT + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] mem [N];

  logic          beat;
  logic          last_idx;
  logic [AW-1:0] waddr;
  logic [9:0]    rel_x;
  logic [9:0]    rel_y;
  logic          hit;
  logic          rd_gate;
  logic [AW-1:0] raddr;

  assign beat     = (state == LOAD) && wr_valid;
  assign last_idx = (col == COL_LAST) && (row == ROW_LAST);
  assign waddr    = AW'(32'(row) * SPRITE_WIDTH + 32'(col));

  // RAM contents survive reset so a partially loaded sprite stays in place.
  always_ff @(posedge clk) begin
    if (beat) mem[waddr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      col      <= '0;
      row      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            wr_ready <= 1'b1;
            busy     <= 1'b1;
            error    <= 1'b0;
            col      <= '0;
            row      <= '0;
          end
        end
        LOAD: begin
          if (wr_valid) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            // Either the frame is full or the source says it ended; a mismatch is a framing error.
            if (last_idx || wr_last) begin
              state    <= DONE;
              wr_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              error    <= (last_idx != wr_last);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Modulo-1024 subtraction makes rasters left of / above the sprite wrap large and miss.
  assign rel_x = current_pixel_x - posx;
  assign rel_y = current_pixel_y - posy;
  assign hit   = (32'(rel_x) < SPRITE_WIDTH) && (32'(rel_y) < SPRITE_HEIGHT);
  assign raddr = AW'(32'(rel_y) * SPRITE_WIDTH + 32'(rel_x));

`ifdef SPRITE_RAM_LOADER_READ_GUARD_EN
  assign rd_gate = !busy;
`else
  assign rd_gate = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_hit  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_hit  <= hit;
      rd_data <= (hit && rd_gate) ? mem[raddr] : '0;
    end
  end

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Scoreboard bench for sprite_ram_loader: load framing, done/error timing and raster readback.
module tb_sprite_ram_loader;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int N  = W * H;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_last = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [9:0]    cpx = '0, cpy = '0;
  logic [9:0]    posx = 10'd100, posy = 10'd50;
  logic          wr_ready, busy, done, error, rd_hit;
  logic [DW-1:0] rd_data;

  sprite_ram_loader #(.SPRITE_WIDTH(W), .SPRITE_HEIGHT(H), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_last(wr_last), .busy(busy), .done(done), .error(error),
    .current_pixel_x(cpx), .current_pixel_y(cpy), .posx(posx), .posy(posy),
    .rd_data(rd_data), .rd_hit(rd_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          hit;
    logic [DW-1:0] data;
  } rd_exp_t;

  logic [DW-1:0] model [N];
  rd_exp_t       sb [$];
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic rd_exp_t model_rd(input logic [9:0] px, input logic [9:0] py, input bit bsy);
    rd_exp_t    e;
    logic [9:0] rx, ry;
    rx = px - posx;
    ry = py - posy;
    e.hit  = (rx < 10'(W)) && (ry < 10'(H));
    e.data = e.hit ? model[int'(ry) * W + int'(rx)] : '0;
`ifdef SPRITE_RAM_LOADER_READ_GUARD_EN
    if (bsy) e.data = '0;
`else
    if (bsy) e.data = e.data;
`endif
    return e;
  endfunction

  task automatic drive_rd(input logic [9:0] px, input logic [9:0] py, input bit bsy);
    cpx = px;
    cpy = py;
    sb.push_back(model_rd(px, py, bsy));
  endtask

  task automatic pop_rd(input string tag);
    rd_exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_hit"}, 32'(rd_hit), 32'(e.hit));
      chk({tag, "_data"}, 32'(rd_data), 32'(e.data));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int nbeats, input int last_at, input bit gaps,
                         input logic [DW-1:0] xo, input bit exp_err);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("ld_ready", 32'(wr_ready), 32'd1);
    chk("ld_busy", 32'(busy), 32'd1);
    chk("ld_err_clr", 32'(error), 32'd0);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) begin
        wr_valid = 1'b0;
        cyc();
      end
      wr_valid = 1'b1;
      wr_data  = xo ^ DW'(i);
      wr_last  = (i == last_at);
      if (i == 20) drive_rd(posx, posy, 1'b1);
      model[i] = wr_data;
      cyc();
      if (i == 20) pop_rd("ld_midread");
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    chk("ld_done", 32'(done), 32'd1);
    chk("ld_done_ready", 32'(wr_ready), 32'd0);
    chk("ld_done_busy", 32'(busy), 32'd0);
    chk("ld_error", 32'(error), 32'(exp_err));
    cyc();
    chk("ld_done_pulse", 32'(done), 32'd0);
    chk("ld_error_sticky", 32'(error), 32'(exp_err));
  endtask

  task automatic scan(input string tag);
    for (int i = 0; i < N; i++) begin
      drive_rd(10'(int'(posx) + i % W), 10'(int'(posy) + i / W), 1'b0);
      cyc();
      pop_rd(tag);
    end
  endtask

  initial begin
    start    = 1'b1;
    wr_valid = 1'b1;
    cpx      = posx;
    cpy      = posy;
    repeat (3) cyc();
    chk("rst_ready", 32'(wr_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_rd_hit", 32'(rd_hit), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    start    = 1'b0;
    wr_valid = 1'b0;
    rst_n    = 1'b1;
    cyc();
    chk("idle_ready", 32'(wr_ready), 32'd0);

    do_load(N, N - 1, 1'b0, 16'h0000, 1'b0);
    cpx = posx + 10'd5;
    cpy = posy + 10'd3;
    sb.push_back('{hit: 1'b1, data: 16'h0065});
    cyc();
    pop_rd("spec_read");
    scan("scan_full");

    do_load(N, N - 1, 1'b1, 16'hA5A5, 1'b0);
    scan("scan_gaps");

    do_load(11, 10, 1'b0, 16'h8000, 1'b1);
    scan("scan_early");

    do_load(N, -1, 1'b0, 16'h1000, 1'b1);
    wr_valid = 1'b1;
    wr_data  = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("extra_ready", 32'(wr_ready), 32'd0);
      chk("extra_busy", 32'(busy), 32'd0);
    end
    wr_valid = 1'b0;
    scan("scan_missing");

    drive_rd(posx - 10'd1, posy, 1'b0);
    cyc();
    pop_rd("out_left");
    drive_rd(posx + 10'd32, posy, 1'b0);
    cyc();
    pop_rd("out_right");
    drive_rd(posx, posy + 10'd32, 1'b0);
    cyc();
    pop_rd("out_below");
    drive_rd(posx + 10'd31, posy + 10'd31, 1'b0);
    cyc();
    pop_rd("corner");
    posx = 10'd0;
    drive_rd(10'd1023, posy, 1'b0);
    cyc();
    pop_rd("wrap_left");
    posx = 10'd100;

    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("rl_err_clr", 32'(error), 32'd0);
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 16'h7700 | DW'(i);
      model[i] = wr_data;
      cyc();
    end
    wr_valid = 1'b0;
    cpx = posx;
    cpy = posy;
    #2 rst_n = 1'b0;
    #1;
    chk("rl_ready", 32'(wr_ready), 32'd0);
    chk("rl_busy", 32'(busy), 32'd0);
    chk("rl_rd_hit", 32'(rd_hit), 32'd0);
    chk("rl_rd_data", 32'(rd_data), 32'd0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rl_no_done", 32'(done), 32'd0);
      chk("rl_idle", 32'(wr_ready), 32'd0);
    end
    scan("scan_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
